// File: rtl/irq_timer_ctrl_if.sv
// Word-access port shared with data memory: select, direction,
// byte enables, address, write data, registered read data and ack.
interface irq_timer_ctrl_if;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic [31:0] data_rd;
  logic        valid_DM;

  modport master (
    output cs, wr, mask, addr, data_wr,
    input  data_rd, valid_DM
  );

  modport slave (
    input  cs, wr, mask, addr, data_wr,
    output data_rd, valid_DM
  );
endinterface

// File: rtl/irq_timer_ctrl.sv
// Machine timer plus edge-triggered external sources, merged into
// one registered interrupt level for the CSR unit.
module irq_timer_ctrl #(
  parameter int NSRC        = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] irq_src,
  irq_timer_ctrl_if.slave bus,
  output logic            interrupt
);

  typedef enum logic [2:0] {
    R_MTIME_LO    = 3'd0,
    R_MTIME_HI    = 3'd1,
    R_MTIMECMP_LO = 3'd2,
    R_MTIMECMP_HI = 3'd3,
    R_PENDING     = 3'd4,
    R_ENABLE      = 3'd5,
    R_CLAIM       = 3'd6,
    R_CTRL        = 3'd7
  } reg_e;

  logic        wr_en;
  logic        rd_en;
  reg_e        sel;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic [7:0]  prescale_q, prescale_d;
  logic        gie_q, gie_d;
  logic        tie_q, tie_d;

  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] edge_q, edge_d;
  logic [SYNC_STAGES-1:0][NSRC-1:0] sync_q, sync_d;

  logic [31:0] data_rd_q, data_rd_d;
  logic        valid_q, valid_d;
  logic        irq_q, irq_d;

  logic            tick;
  logic            tpend;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] pend_en;
  logic [NSRC-1:0] claim_oh;
  logic [4:0]      claim_id;
  logic            claim_go;
  logic [31:0]     rdata;
  logic [31:0]     ctrl_rd;
  logic [31:0]     ctrl_w;
  logic [31:0]     en_w;
  logic            unused_bits;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[8*i +: 8] = be[i] ? nw[8*i +: 8] : old[8*i +: 8];
    end
    return r;
  endfunction

  assign wr_en = bus.cs & bus.wr;
  assign rd_en = bus.cs & ~bus.wr;
  assign sel   = reg_e'(bus.addr[4:2]);

  assign ctrl_rd = {16'b0, prescale_q, 6'b0, tie_q, gie_q};
  assign ctrl_w  = merge(ctrl_rd, bus.data_wr, bus.mask);
  assign en_w    = merge(32'(enable_q), bus.data_wr, bus.mask);

  assign unused_bits = ^{bus.addr[31:5], bus.addr[1:0],
                         ctrl_w[31:16], ctrl_w[7:2],
                         en_w[31:NSRC]};

  // Source sync chain and edge detect
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = irq_src;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    edge_d = sync_q[SYNC_STAGES-1];
    rise   = sync_q[SYNC_STAGES-1] & ~edge_q;
  end

  // Lowest enabled pending source wins the claim
  always_comb begin
    pend_en  = pending_q & enable_q;
    claim_oh = pend_en & (~pend_en + NSRC'(1));
    claim_id = '0;
    for (int i = NSRC-1; i >= 0; i--) begin
      if (pend_en[i]) claim_id = 5'(i + 1);
    end
    claim_go = rd_en && (sel == R_CLAIM);
  end

  always_comb begin
    rdata = '0;
    unique case (sel)
      R_MTIME_LO:    rdata = mtime_q[31:0];
      R_MTIME_HI:    rdata = mtime_q[63:32];
      R_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
      R_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
      R_PENDING:     rdata = 32'(pending_q);
      R_ENABLE:      rdata = 32'(enable_q);
      R_CLAIM:       rdata = {27'b0, claim_id};
      R_CTRL:        rdata = ctrl_rd;
      default:       rdata = '0;
    endcase
  end

  always_comb begin
    tick       = (pcnt_q == prescale_q);
    pcnt_d     = tick ? 8'd0 : pcnt_q + 8'd1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    prescale_d = prescale_q;
    gie_d      = gie_q;
    tie_d      = tie_q;
    enable_d   = enable_q;

    if (wr_en) begin
      unique case (sel)
        R_MTIME_LO: mtime_d = {mtime_q[63:32],
          merge(mtime_q[31:0], bus.data_wr, bus.mask)};
        R_MTIME_HI: mtime_d = {
          merge(mtime_q[63:32], bus.data_wr, bus.mask),
          mtime_q[31:0]};
        R_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32],
          merge(mtimecmp_q[31:0], bus.data_wr, bus.mask)};
        R_MTIMECMP_HI: mtimecmp_d = {
          merge(mtimecmp_q[63:32], bus.data_wr, bus.mask),
          mtimecmp_q[31:0]};
        R_ENABLE: enable_d = en_w[NSRC-1:0];
        R_CTRL: begin
          gie_d      = ctrl_w[0];
          tie_d      = ctrl_w[1];
          prescale_d = ctrl_w[15:8];
          pcnt_d     = 8'd0;
        end
        default: ;
      endcase
    end

    // A fresh edge beats a same-cycle claim clear
    pending_d = pending_q;
    if (claim_go) pending_d = pending_q & ~claim_oh;
    pending_d = pending_d | rise;

    data_rd_d = rd_en ? rdata : data_rd_q;
    valid_d   = bus.cs;

    tpend = (mtime_q >= mtimecmp_q);
    irq_d = gie_q & ((tie_q & tpend) | (|pend_en));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      pcnt_q     <= '0;
      prescale_q <= '0;
      gie_q      <= 1'b0;
      tie_q      <= 1'b0;
      enable_q   <= '0;
      pending_q  <= '0;
      edge_q     <= '0;
      sync_q     <= '0;
      data_rd_q  <= '0;
      valid_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      pcnt_q     <= pcnt_d;
      prescale_q <= prescale_d;
      gie_q      <= gie_d;
      tie_q      <= tie_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      edge_q     <= edge_d;
      sync_q     <= sync_d;
      data_rd_q  <= data_rd_d;
      valid_q    <= valid_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.data_rd  = data_rd_q;
  assign bus.valid_DM = valid_q;
  assign interrupt    = irq_q;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl: reset state, timer, external
// sources, claim conflicts, mtime writes/wrap, mid-access reset.
module tb_irq_timer_ctrl;

  localparam logic [31:0] A_MTLO = 32'h00;
  localparam logic [31:0] A_MTHI = 32'h04;
  localparam logic [31:0] A_CMLO = 32'h08;
  localparam logic [31:0] A_CMHI = 32'h0C;
  localparam logic [31:0] A_PEND = 32'h10;
  localparam logic [31:0] A_EN   = 32'h14;
  localparam logic [31:0] A_CLM  = 32'h18;
  localparam logic [31:0] A_CTRL = 32'h1C;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_src = '0;
  logic       interrupt;
  int         vecs = 0;
  int         errs = 0;

  irq_timer_ctrl_if bus ();

  irq_timer_ctrl #(
    .NSRC(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .irq_src(irq_src),
    .bus(bus),
    .interrupt(interrupt)
  );

  always #5 clk = ~clk;

  task automatic bus_wr(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] m);
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b1;
    bus.addr = a; bus.data_wr = d; bus.mask = m;
    @(negedge clk);
    bus.cs = 1'b0; bus.wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a,
                        output logic [31:0] d,
                        output logic v);
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b0; bus.addr = a;
    @(negedge clk);
    v = bus.valid_DM; d = bus.data_rd;
    bus.cs = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic v;
    logic [31:0] exp_t [8];
    exp_t = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h0, 32'h0, 32'h0, 32'h0};
    rst = 1'b1; irq_src = '0;
    bus.cs = 1'b0; bus.wr = 1'b0; bus.mask = 4'hF;
    bus.addr = '0; bus.data_wr = '0;
    repeat (3) @(negedge clk);
    vecs++;
    if ({interrupt, bus.valid_DM, bus.data_rd} !== 34'b0) begin
      errs++;
      $display("FAIL reset_outputs: got irq=%b v=%b d=%h exp 0 0 0",
               interrupt, bus.valid_DM, bus.data_rd);
    end
    rst = 1'b0;
    bus.cs = 1'b1; bus.wr = 1'b0; bus.addr = A_MTLO;
    @(negedge clk);
    v = bus.valid_DM; d = bus.data_rd;
    bus.cs = 1'b0;
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL reset_mtime_lo: got v=%b d=%h exp v=1 d=0", v, d);
    end
    @(negedge clk);
    vecs++;
    if (bus.valid_DM !== 1'b0) begin
      errs++;
      $display("FAIL valid_one_cycle: got %b exp 0", bus.valid_DM);
    end
    for (int i = 1; i < 8; i++) begin
      bus_rd(32'(i * 4), d, v);
      vecs++;
      if (v !== 1'b1 || d !== exp_t[i] || interrupt !== 1'b0) begin
        errs++;
        $display("FAIL reset_reg%0d: got v=%b d=%h irq=%b exp 1 %h 0",
                 i, v, d, interrupt, exp_t[i]);
      end
      @(negedge clk);
      vecs++;
      if (bus.valid_DM !== 1'b0) begin
        errs++;
        $display("FAIL valid_drop%0d: got %b exp 0", i, bus.valid_DM);
      end
    end
  endtask

  task automatic test_timer();
    logic [31:0] d;
    logic v;
    int bad;
    bus_wr(A_CMHI, 32'h0, 4'hF);
    bus_wr(A_CMLO, 32'd10, 4'hF);
    bus_wr(A_MTLO, 32'h0, 4'hF);
    bus_wr(A_CTRL, 32'h0000_0303, 4'hF);
    // mtime reaches 10 in the 33rd cycle from here
    bad = 0;
    for (int i = 0; i < 33; i++) begin
      if (i > 0) @(negedge clk);
      if (interrupt !== 1'b0) bad++;
    end
    vecs++;
    if (bad != 0) begin
      errs++;
      $display("FAIL timer_early: got %0d high samples exp 0", bad);
    end
    @(negedge clk);
    vecs++;
    if (interrupt !== 1'b1) begin
      errs++;
      $display("FAIL timer_rise: got %b exp 1", interrupt);
    end
    bus_rd(A_MTLO, d, v);
    vecs++;
    if (v !== 1'b1 || d !== 32'd10) begin
      errs++;
      $display("FAIL timer_mtime10: got v=%b d=%0d exp 1 10", v, d);
    end
    bus_rd(A_MTLO, d, v);
    vecs++;
    if (v !== 1'b1 || d !== 32'd11) begin
      errs++;
      $display("FAIL timer_mtime11: got v=%b d=%0d exp 1 11", v, d);
    end
    bus_wr(A_CMLO, 32'd100, 4'hF);
    vecs++;
    if (interrupt !== 1'b1) begin
      errs++;
      $display("FAIL timer_hold: got %b exp 1", interrupt);
    end
    @(negedge clk);
    vecs++;
    if (interrupt !== 1'b0) begin
      errs++;
      $display("FAIL timer_drop: got %b exp 0", interrupt);
    end
    bus_wr(A_CTRL, 32'h0, 4'hF);
  endtask

  task automatic test_ext_claim();
    logic [31:0] d;
    logic v;
    bus_wr(A_EN, 32'h0A, 4'hF);
    bus_wr(A_CTRL, 32'h1, 4'hF);
    @(negedge clk);
    irq_src = 8'h0A;
    repeat (3) @(negedge clk);
    vecs++;
    if (interrupt !== 1'b0) begin
      errs++;
      $display("FAIL ext_early: got %b exp 0", interrupt);
    end
    @(negedge clk);
    vecs++;
    if (interrupt !== 1'b1) begin
      errs++;
      $display("FAIL ext_rise: got %b exp 1", interrupt);
    end
    irq_src = '0;
    bus_rd(A_PEND, d, v);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0A) begin
      errs++;
      $display("FAIL ext_pending: got v=%b d=%h exp 1 0a", v, d);
    end
    bus_rd(A_CLM, d, v);
    vecs++;
    if (d !== 32'd2) begin
      errs++;
      $display("FAIL claim_first: got %0d exp 2", d);
    end
    bus_rd(A_CLM, d, v);
    vecs++;
    if (d !== 32'd4 || interrupt !== 1'b1) begin
      errs++;
      $display("FAIL claim_second: got %0d irq=%b exp 4 1",
               d, interrupt);
    end
    @(negedge clk);
    vecs++;
    if (interrupt !== 1'b0) begin
      errs++;
      $display("FAIL claim_irq_fall: got %b exp 0", interrupt);
    end
    bus_rd(A_CLM, d, v);
    vecs++;
    if (v !== 1'b1 || d !== 32'd0) begin
      errs++;
      $display("FAIL claim_empty: got v=%b d=%0d exp 1 0", v, d);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] d;
    logic v;
    irq_src[1] = 1'b1;
    repeat (4) @(negedge clk);
    irq_src[1] = 1'b0;
    repeat (4) @(negedge clk);
    bus_wr(A_EN, 32'h0, 4'hF);
    bus_rd(A_PEND, d, v);
    vecs++;
    if (d !== 32'h02) begin
      errs++;
      $display("FAIL disable_keeps_pend: got %h exp 02", d);
    end
    bus_rd(A_CLM, d, v);
    vecs++;
    if (d !== 32'd0) begin
      errs++;
      $display("FAIL claim_disabled: got %0d exp 0", d);
    end
    bus_wr(A_EN, 32'h0A, 4'hF);
    @(negedge clk);
    irq_src[1] = 1'b1;
    @(negedge clk);
    // claim is accepted in the cycle the synchronized edge fires
    bus_rd(A_CLM, d, v);
    vecs++;
    if (d !== 32'd2) begin
      errs++;
      $display("FAIL conflict_claim: got %0d exp 2", d);
    end
    bus_rd(A_PEND, d, v);
    vecs++;
    if (d !== 32'h02) begin
      errs++;
      $display("FAIL conflict_pend: got %h exp 02", d);
    end
    bus_rd(A_CLM, d, v);
    vecs++;
    if (d !== 32'd2) begin
      errs++;
      $display("FAIL conflict_reclaim: got %0d exp 2", d);
    end
    irq_src = '0;
  endtask

  task automatic test_mtime_write();
    logic [31:0] d;
    logic v;
    bus_wr(A_CTRL, 32'h0000_FF00, 4'hF);
    bus_wr(A_MTHI, 32'h0, 4'hF);
    bus_wr(A_MTLO, 32'h1234_5678, 4'hF);
    bus_wr(A_MTLO, 32'hAAAA_5555, 4'b0011);
    bus_rd(A_MTLO, d, v);
    vecs++;
    if (v !== 1'b1 || d !== 32'h1234_5555) begin
      errs++;
      $display("FAIL mtime_bytes: got v=%b d=%h exp 1 12345555", v, d);
    end
    bus_wr(A_CTRL, 32'h0, 4'hF);
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.mask = 4'hF;
    bus.addr = A_MTHI; bus.data_wr = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.addr = A_MTLO;
    @(negedge clk);
    bus.wr = 1'b0; bus.addr = A_MTHI;
    @(negedge clk);
    bus.addr = A_MTLO;
    vecs++;
    if (bus.valid_DM !== 1'b1 || bus.data_rd !== 32'hFFFF_FFFF) begin
      errs++;
      $display("FAIL wrap_before: got v=%b d=%h exp 1 ffffffff",
               bus.valid_DM, bus.data_rd);
    end
    @(negedge clk);
    bus.addr = A_MTHI;
    vecs++;
    if (bus.valid_DM !== 1'b1 || bus.data_rd !== 32'h0) begin
      errs++;
      $display("FAIL wrap_lo: got v=%b d=%h exp 1 0",
               bus.valid_DM, bus.data_rd);
    end
    @(negedge clk);
    bus.cs = 1'b0;
    vecs++;
    if (bus.valid_DM !== 1'b1 || bus.data_rd !== 32'h0) begin
      errs++;
      $display("FAIL wrap_hi: got v=%b d=%h exp 1 0",
               bus.valid_DM, bus.data_rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic v;
    @(negedge clk);
    bus.cs = 1'b1; bus.wr = 1'b1; bus.mask = 4'hF;
    bus.addr = A_EN; bus.data_wr = 32'hFFFF_FF33;
    @(negedge clk);
    bus.wr = 1'b0;
    vecs++;
    if (bus.valid_DM !== 1'b1) begin
      errs++;
      $display("FAIL b2b_wr_ack: got %b exp 1", bus.valid_DM);
    end
    @(negedge clk);
    bus.cs = 1'b0;
    vecs++;
    if (bus.valid_DM !== 1'b1 || bus.data_rd !== 32'h33) begin
      errs++;
      $display("FAIL b2b_rd: got v=%b d=%h exp 1 33",
               bus.valid_DM, bus.data_rd);
    end
    bus_wr(A_EN, 32'h0, 4'b0000);
    bus_wr(A_PEND, 32'hFF, 4'hF);
    bus_wr(A_CTRL, 32'hFFFF_FFFF, 4'b0100);
    bus_rd(A_EN, d, v);
    vecs++;
    if (d !== 32'h33) begin
      errs++;
      $display("FAIL mask_none: got %h exp 33", d);
    end
    bus_rd(A_PEND, d, v);
    vecs++;
    if (d !== 32'h0) begin
      errs++;
      $display("FAIL ro_pending: got %h exp 0", d);
    end
    bus_rd(A_CTRL, d, v);
    vecs++;
    if (d !== 32'h0) begin
      errs++;
      $display("FAIL ctrl_unused: got %h exp 0", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic v;
    bus_wr(A_EN, 32'hFF, 4'hF);
    bus_wr(A_CTRL, 32'h0000_0501, 4'hF);
    @(negedge clk);
    irq_src = 8'hFF;
    repeat (4) @(negedge clk);
    irq_src = '0;
    repeat (4) @(negedge clk);
    bus_rd(A_PEND, d, v);
    vecs++;
    if (d !== 32'hFF || interrupt !== 1'b1) begin
      errs++;
      $display("FAIL pre_rst: got d=%h irq=%b exp ff 1", d, interrupt);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.cs = 1'b1; bus.wr = 1'b0; bus.addr = A_PEND;
    @(negedge clk);
    vecs++;
    if ({bus.valid_DM, interrupt, bus.data_rd} !== 34'b0) begin
      errs++;
      $display("FAIL mid_rst: got v=%b irq=%b d=%h exp 0 0 0",
               bus.valid_DM, interrupt, bus.data_rd);
    end
    bus.cs = 1'b0; rst = 1'b0;
    bus_rd(A_PEND, d, v);
    vecs++;
    if (v !== 1'b1 || d !== 32'h0) begin
      errs++;
      $display("FAIL rst_pending: got v=%b d=%h exp 1 0", v, d);
    end
    bus_rd(A_EN, d, v);
    vecs++;
    if (d !== 32'h0) begin
      errs++;
      $display("FAIL rst_enable: got %h exp 0", d);
    end
    bus_rd(A_CTRL, d, v);
    vecs++;
    if (d !== 32'h0) begin
      errs++;
      $display("FAIL rst_ctrl: got %h exp 0", d);
    end
    bus_rd(A_CMLO, d, v);
    vecs++;
    if (d !== 32'hFFFF_FFFF) begin
      errs++;
      $display("FAIL rst_cmp_lo: got %h exp ffffffff", d);
    end
    bus_rd(A_MTHI, d, v);
    vecs++;
    if (d !== 32'h0) begin
      errs++;
      $display("FAIL rst_mtime_hi: got %h exp 0", d);
    end
  endtask

  initial begin
    test_reset();
    test_timer();
    test_ext_claim();
    test_conflict();
    test_mtime_write();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
